// File: rtl/apb_master_bridge_pkg.sv
// Shared APB definitions for the bridge and the GPIO/UART slaves.
// Holds the bridge state encoding, slave-select codes and default bus widths.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  localparam logic SEL_GPIO = 1'b0;
  localparam logic SEL_UART = 1'b1;

  localparam int APB_ADDR_W = 8;
  localparam int APB_DATA_W = 8;

endpackage

// File: rtl/apb_master_bridge_if.sv
// Command/response handshake plus the APB requester-side bus, bundled together.
// The master modport is the bridge; the slave modport is the controller/peripheral side.
interface apb_master_bridge_if #(
  parameter int ADDR_W = apb_pkg::APB_ADDR_W,
  parameter int DATA_W = apb_pkg::APB_DATA_W
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic              cmd_sel;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              PSEL1;
  logic              PSEL2;
  logic              PENABLE;
  logic [ADDR_W-1:0] PADDR;
  logic              PWRITE;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;

  modport master (
    input  cmd_valid, cmd_write, cmd_sel, cmd_addr, cmd_wdata, PRDATA, PREADY,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    output PSEL1, PSEL2, PENABLE, PADDR, PWRITE, PWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_sel, cmd_addr, cmd_wdata, PRDATA, PREADY,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    input  PSEL1, PSEL2, PENABLE, PADDR, PWRITE, PWDATA
  );
endinterface

// File: rtl/apb_master_bridge_wait_timer.sv
// ACCESS-phase wait-state counter; o_tc flags the cycle where the count equals TIMEOUT.
// A TIMEOUT of 0 holds o_tc low, so a stalled slave is waited on indefinitely.
module apb_wait_timer #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic PCLK,
  input  logic PRESETn,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tc = (TIMEOUT != 0) && (r_cnt == CNT_W'(TIMEOUT));

endmodule

// File: rtl/apb_master_bridge.sv
// APB requester for the GPIO (PSEL1) and UART (PSEL2) slaves: one command in,
// SETUP/ACCESS on the bus, one-cycle response strobe out (data or timeout error).
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic                PCLK,
  input  logic                PRESETn,
  apb_master_bridge_if.master bus
);

  // state  | meaning
  // IDLE   | cmd_ready high, bus deselected; accepts a command
  // SETUP  | PSELx high, PENABLE low; wait counter cleared
  // ACCESS | PSELx and PENABLE high; waiting on PREADY or timeout

  state_e            r_state;
  state_e            w_state_nxt;
  logic              w_accept;
  logic              w_done;
  logic              w_abort;
  logic              w_clr;
  logic              w_en;
  logic              w_tc;

  logic              r_psel1;
  logic              r_psel2;
  logic              r_penable;
  logic [ADDR_W-1:0] r_paddr;
  logic              r_pwrite;
  logic [DATA_W-1:0] r_pwdata;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_rsp_err;

  apb_wait_timer #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_wait_timer (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .i_clr   (w_clr),
    .i_en    (w_en),
    .o_tc    (w_tc)
  );

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_done      = 1'b0;
    w_abort     = 1'b0;
    w_clr       = 1'b0;
    w_en        = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.cmd_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = SETUP;
        end
      end
      SETUP: begin
        w_clr       = 1'b1;
        w_state_nxt = ACCESS;
      end
      ACCESS: begin
        // PREADY wins over a coincident terminal count
        if (bus.PREADY) begin
          w_done      = 1'b1;
          w_state_nxt = IDLE;
        end else if (w_tc) begin
          w_abort     = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_en        = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_psel1     <= 1'b0;
      r_psel2     <= 1'b0;
      r_penable   <= 1'b0;
      r_paddr     <= '0;
      r_pwrite    <= 1'b0;
      r_pwdata    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= w_done | w_abort;
      if (w_accept) begin
        r_psel1  <= (bus.cmd_sel == SEL_GPIO);
        r_psel2  <= (bus.cmd_sel == SEL_UART);
        r_paddr  <= bus.cmd_addr;
        r_pwrite <= bus.cmd_write;
        r_pwdata <= bus.cmd_wdata;
      end
      if (r_state == SETUP) begin
        r_penable <= 1'b1;
      end
      // Address, direction and write data deliberately keep their last values
      if (w_done || w_abort) begin
        r_psel1     <= 1'b0;
        r_psel2     <= 1'b0;
        r_penable   <= 1'b0;
        r_rsp_rdata <= (w_done && !r_pwrite) ? bus.PRDATA : '0;
        r_rsp_err   <= w_abort;
      end
    end
  end

  assign bus.cmd_ready = (r_state == IDLE) && PRESETn;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.PSEL1     = r_psel1;
  assign bus.PSEL2     = r_psel2;
  assign bus.PENABLE   = r_penable;
  assign bus.PADDR     = r_paddr;
  assign bus.PWRITE    = r_pwrite;
  assign bus.PWDATA    = r_pwdata;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge (TIMEOUT=3): scoreboard of expected
// responses with expected arrival cycle, plus a wait-state slave responder.
module tb_apb_master_bridge;
  import apb_pkg::*;

  localparam int T = 3;

  logic PCLK    = 1'b0;
  logic PRESETn = 1'b0;

  apb_master_bridge_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  apb_master_bridge #(
    .ADDR_W  (8),
    .DATA_W  (8),
    .TIMEOUT (T),
    .CNT_W   (4)
  ) dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .bus     (bus)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    logic [7:0] rdata;
    logic       err;
    int         cyc;
  } exp_t;

  exp_t       sb[$];
  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;
  int         ws       = 0;
  logic [7:0] rd_val   = 8'h00;
  int         acc_n    = 0;
  int         last_acc = 0;
  bit         psel2_seen = 1'b0;
  logic [7:0] setup_addr  = 8'h00;
  logic [7:0] setup_wdata = 8'h00;
  logic       setup_write = 1'b0;

  always @(posedge PCLK) cyc <= cyc + 1;

  // Slave responder: PREADY high on access cycle number ws (0-based), hold checks
  initial begin
    bus.PREADY = 1'b0;
    bus.PRDATA = 8'h00;
    forever begin
      @(negedge PCLK);
      if (bus.PSEL2) psel2_seen = 1'b1;
      checks++;
      if (bus.PSEL1 && bus.PSEL2) begin
        failures++;
        $display("FAIL psel_onehot: got PSEL1=%b PSEL2=%b expected at most one high", bus.PSEL1, bus.PSEL2);
      end
      if ((bus.PSEL1 || bus.PSEL2) && !bus.PENABLE) begin
        setup_addr  = bus.PADDR;
        setup_wdata = bus.PWDATA;
        setup_write = bus.PWRITE;
      end
      if ((bus.PSEL1 || bus.PSEL2) && bus.PENABLE) begin
        checks++;
        if ({bus.PADDR, bus.PWDATA, bus.PWRITE} !== {setup_addr, setup_wdata, setup_write}) begin
          failures++;
          $display("FAIL bus_hold: got addr=%h wdata=%h write=%b expected addr=%h wdata=%h write=%b",
                   bus.PADDR, bus.PWDATA, bus.PWRITE, setup_addr, setup_wdata, setup_write);
        end
        bus.PREADY = (acc_n == ws);
        acc_n++;
      end else begin
        if (acc_n != 0) last_acc = acc_n;
        acc_n = 0;
        bus.PREADY = 1'b0;
      end
      bus.PRDATA = rd_val;
    end
  end

  // Response monitor: pops the scoreboard on every rsp_valid
  initial begin
    exp_t e;
    forever begin
      @(negedge PCLK);
      if (bus.rsp_valid === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_rsp: got rsp_valid=1 at cycle %0d expected no response", cyc);
        end else begin
          e = sb.pop_front();
          if (bus.rsp_rdata !== e.rdata || bus.rsp_err !== e.err || cyc !== e.cyc) begin
            failures++;
            $display("FAIL rsp: got rdata=%h err=%b cycle=%0d expected rdata=%h err=%b cycle=%0d",
                     bus.rsp_rdata, bus.rsp_err, cyc, e.rdata, e.err, e.cyc);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by time limit expected bench to finish");
    $fatal(1, "watchdog expired");
  end

  // Present a command at #1 after a posedge while IDLE; queue its expected response
  task automatic send(input logic sel, input logic write, input logic [7:0] addr,
                      input logic [7:0] wdata, input int wst,
                      input logic [7:0] exp_rd, input logic exp_err);
    ws            = wst;
    bus.cmd_valid = 1'b1;
    bus.cmd_sel   = sel;
    bus.cmd_write = write;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wdata;
    sb.push_back('{rdata: exp_rd, err: exp_err, cyc: cyc + 3 + (exp_err ? T : wst)});
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 40 && (sb.size() != 0 || bus.PSEL1 || bus.PSEL2); i++) begin
      @(posedge PCLK); #1;
    end
    checks++;
    if (sb.size() != 0 || bus.PSEL1 || bus.PSEL2) begin
      failures++;
      $display("FAIL %s_timeout: got %0d pending responses expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    bus.cmd_valid = 1'b0;
    bus.cmd_sel   = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 8'h00;
    bus.cmd_wdata = 8'h00;
    PRESETn = 1'b0;
    repeat (2) @(posedge PCLK);
    #1;
    checks++;
    if ({bus.PSEL1, bus.PSEL2, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA,
         bus.rsp_valid, bus.rsp_rdata, bus.rsp_err} !== 29'd0) begin
      failures++;
      $display("FAIL reset_outputs: got sel=%b%b en=%b wr=%b addr=%h wdata=%h rv=%b rd=%h err=%b expected all 0",
               bus.PSEL1, bus.PSEL2, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA,
               bus.rsp_valid, bus.rsp_rdata, bus.rsp_err);
    end
    PRESETn = 1'b1;
    #1;
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready: got %b expected 1", bus.cmd_ready);
    end
    @(posedge PCLK); #1;
  endtask

  task automatic test_uart_write();
    rd_val = 8'hEE;
    send(SEL_UART, 1'b1, 8'h04, 8'h5A, 0, 8'h00, 1'b0);
    @(posedge PCLK); #1;
    bus.cmd_valid = 1'b0;
    @(negedge PCLK);
    checks++;
    if ({bus.PSEL1, bus.PSEL2, bus.PENABLE} !== 3'b010) begin
      failures++;
      $display("FAIL uart_setup: got sel1/sel2/en=%b%b%b expected 010", bus.PSEL1, bus.PSEL2, bus.PENABLE);
    end
    @(negedge PCLK);
    checks++;
    if ({bus.PSEL2, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA} !== {3'b111, 8'h04, 8'h5A}) begin
      failures++;
      $display("FAIL uart_access: got sel2=%b en=%b wr=%b addr=%h wdata=%h expected 1 1 1 04 5a",
               bus.PSEL2, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA);
    end
    @(negedge PCLK);
    checks++;
    if ({bus.PSEL1, bus.PSEL2, bus.PENABLE} !== 3'b000) begin
      failures++;
      $display("FAIL uart_release: got sel1/sel2/en=%b%b%b expected 000", bus.PSEL1, bus.PSEL2, bus.PENABLE);
    end
    @(posedge PCLK); #1;
    wait_done("uart_write");
  endtask

  task automatic test_gpio_read();
    psel2_seen = 1'b0;
    rd_val     = 8'hC3;
    send(SEL_GPIO, 1'b0, 8'h10, 8'h00, 2, 8'hC3, 1'b0);
    @(posedge PCLK); #1;
    bus.cmd_valid = 1'b0;
    wait_done("gpio_read");
    checks++;
    if (psel2_seen !== 1'b0 || last_acc != 3) begin
      failures++;
      $display("FAIL gpio_read_bus: got psel2_seen=%b access_cycles=%0d expected 0 and 3", psel2_seen, last_acc);
    end
  endtask

  task automatic test_timeout();
    rd_val = 8'h77;
    send(SEL_UART, 1'b0, 8'h08, 8'h00, 1000, 8'h00, 1'b1);
    @(posedge PCLK); #1;
    bus.cmd_valid = 1'b0;
    wait_done("timeout");
    checks++;
    if (last_acc != T + 1 || bus.PENABLE !== 1'b0 || bus.cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL timeout_bus: got access_cycles=%0d en=%b ready=%b expected %0d 0 1",
               last_acc, bus.PENABLE, bus.cmd_ready, T + 1);
    end
  endtask

  task automatic test_back_to_back();
    rd_val = 8'hEE;
    send(SEL_GPIO, 1'b1, 8'h20, 8'hA1, 0, 8'h00, 1'b0);
    @(posedge PCLK); #1;
    bus.cmd_valid = 1'b0;
    @(posedge PCLK); #1;
    @(posedge PCLK); #1;
    checks++;
    if ({bus.rsp_valid, bus.cmd_ready} !== 2'b11) begin
      failures++;
      $display("FAIL b2b_rsp_cycle: got rsp_valid=%b cmd_ready=%b expected 1 1", bus.rsp_valid, bus.cmd_ready);
    end
    send(SEL_GPIO, 1'b1, 8'h20, 8'hB2, 0, 8'h00, 1'b0);
    @(posedge PCLK); #1;
    bus.cmd_valid = 1'b0;
    checks++;
    if ({bus.PSEL1, bus.PENABLE, bus.PADDR, bus.PWDATA} !== {2'b10, 8'h20, 8'hB2}) begin
      failures++;
      $display("FAIL b2b_setup: got sel1=%b en=%b addr=%h wdata=%h expected 1 0 20 b2",
               bus.PSEL1, bus.PENABLE, bus.PADDR, bus.PWDATA);
    end
    wait_done("back_to_back");
  endtask

  task automatic test_hold_cmd();
    rd_val = 8'hEE;
    send(SEL_UART, 1'b1, 8'h30, 8'h11, 0, 8'h00, 1'b0);
    for (int k = 0; k < 2; k++) begin
      @(posedge PCLK); #1;
      bus.cmd_wdata = 8'h40 + 8'(k);
    end
    @(posedge PCLK); #1;
    bus.cmd_valid = 1'b0;
    repeat (5) @(posedge PCLK);
    #1;
    wait_done("hold_cmd");
    checks++;
    if ({bus.PWDATA, bus.PADDR, bus.PSEL2} !== {8'h11, 8'h30, 1'b0}) begin
      failures++;
      $display("FAIL hold_cmd_final: got wdata=%h addr=%h sel2=%b expected 11 30 0",
               bus.PWDATA, bus.PADDR, bus.PSEL2);
    end
  endtask

  task automatic test_reset_mid();
    rd_val = 8'h55;
    send(SEL_UART, 1'b1, 8'h44, 8'h99, 1000, 8'h00, 1'b1);
    @(posedge PCLK); #1;
    bus.cmd_valid = 1'b0;
    @(posedge PCLK); #1;
    @(posedge PCLK); #1;
    checks++;
    if ({bus.PSEL2, bus.PENABLE} !== 2'b11) begin
      failures++;
      $display("FAIL midrst_pre: got sel2=%b en=%b expected 1 1", bus.PSEL2, bus.PENABLE);
    end
    PRESETn = 1'b0;
    #1;
    checks++;
    if ({bus.PSEL2, bus.PENABLE} !== 2'b00) begin
      failures++;
      $display("FAIL midrst_async: got sel2=%b en=%b expected 0 0", bus.PSEL2, bus.PENABLE);
    end
    sb.delete();
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
    #1;
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL midrst_ready: got %b expected 1", bus.cmd_ready);
    end
    repeat (8) @(posedge PCLK);
    #1;
  endtask

  initial begin
    test_reset();
    test_uart_write();
    test_gpio_read();
    test_timeout();
    test_back_to_back();
    test_hold_cmd();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- APB requester driving the peripheral bus shared by the GPIO slave (PSEL1) and the UART slave (PSEL2).
- Accepts single read/write commands from an internal controller over a valid/ready interface and sequences APB SETUP/ACCESS phases.
- Returns read data, or an error flag on wait-state timeout, over a one-cycle response strobe.
- Sits between the system controller and the APB peripherals.

Parameters:
- ADDR_W, 8, PADDR/cmd_addr width
- DATA_W, 8, PWDATA/PRDATA/cmd_wdata/rsp_rdata width
- TIMEOUT, 15, maximum ACCESS-phase cycles with PREADY low before abort; 0 disables timeout
- CNT_W, 4, timeout counter width; must satisfy 2**CNT_W > TIMEOUT

Ports:
- PCLK  in  1  bus clock; all logic on rising edge
- PRESETn  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_write  in  1  1=write, 0=read
- cmd_sel  in  1  0=GPIO (PSEL1), 1=UART (PSEL2)
- cmd_addr  in  ADDR_W  target register address
- cmd_wdata  in  DATA_W  write data
- rsp_valid  out  1  one-cycle completion strobe
- rsp_rdata  out  DATA_W  captured PRDATA; 0 for writes and errors
- rsp_err  out  1  qualifies rsp_valid; 1 = timeout abort
- PSEL1  out  1  GPIO slave select
- PSEL2  out  1  UART slave select
- PENABLE  out  1  APB access phase
- PADDR  out  ADDR_W  APB address
- PWRITE  out  1  APB direction
- PWDATA  out  DATA_W  APB write data
- PRDATA  in  DATA_W  read data from selected slave (muxed externally)
- PREADY  in  1  slave ready; tie 1 for zero-wait slaves

Behaviour:
- Reset (async, PRESETn=0): state IDLE. PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err and the wait counter all 0. cmd_ready is 1 once PRESETn is high.
- Bus outputs drop on the asserting edge of PRESETn, not at the next clock. An in-flight transfer is abandoned and produces no response.
- FSM states:
  - IDLE: cmd_ready=1. On cmd_valid, register cmd_sel, cmd_write, cmd_addr, cmd_wdata into PSELx, PWRITE, PADDR, PWDATA, then go to SETUP.
  - SETUP: cmd_ready=0. Selected PSELx=1, PENABLE=0. Clear wait counter. Next cycle go to ACCESS unconditionally.
  - ACCESS: cmd_ready=0. PSELx=1, PENABLE=1.
    - PREADY=1: complete.
    - PREADY=0 and counter==TIMEOUT (TIMEOUT>0): abort.
    - Otherwise: increment counter and stay in ACCESS.
- Completion (edge leaving ACCESS):
  - Drop PSELx and PENABLE, go to IDLE.
  - Next cycle rsp_valid=1 for exactly one cycle.
  - Read: rsp_rdata = PRDATA sampled on the completing edge.
  - Write: rsp_rdata = 0.
  - rsp_err = 0.
- Abort: same timing as completion, but rsp_err=1 and rsp_rdata=0. The slave sees PSEL/PENABLE drop without PREADY.
- Latency, zero-wait slave:
  - Command accepted at edge N.
  - SETUP in cycle N+1, ACCESS in cycle N+2.
  - rsp_valid in cycle N+3.
  - Minimum 3 cycles per transfer.
- Back-to-back: a command may be accepted in the same cycle rsp_valid is high, because the state is IDLE then.
- Signal hold rules:
  - PADDR, PWRITE, PWDATA stay stable from SETUP through the end of ACCESS.
  - After the transfer they keep their last values; only PSELx/PENABLE return to 0.
- Exactly one PSELx is high in SETUP/ACCESS. Both are 0 in IDLE.
- Timeout boundaries:
  - TIMEOUT=T aborts after T+1 ACCESS cycles with PREADY low.
  - PREADY rising on the same edge as counter==TIMEOUT counts as completion, not abort.
- cmd_* inputs are ignored while cmd_ready=0; no buffering.

Decomposition:
- Shared package apb_pkg:
  - state enum {IDLE, SETUP, ACCESS}
  - select encodings SEL_GPIO=0, SEL_UART=1
  - default ADDR_W/DATA_W constants, reused by the GPIO and UART slaves
- Sub-module apb_wait_timer: clear/enable counter with terminal-count output at TIMEOUT, gated off when TIMEOUT=0.
- FSM and bus registers stay in apb_master_bridge.

Test Plan:
- Reset mid-transfer: assert PRESETn=0 during ACCESS -> PSEL2/PENABLE go 0 immediately; no rsp_valid after release; cmd_ready=1.
- UART write, PREADY tied 1: cmd_sel=1, addr=0x04, wdata=0x5A -> PSEL2=1/PENABLE=0 one cycle, then PENABLE=1 one cycle with PADDR=0x04, PWDATA=0x5A, PWRITE=1. rsp_valid 3 cycles after accept; rsp_err=0.
- GPIO read with 2 wait states: PRDATA=0xC3 when PREADY rises on the 3rd ACCESS cycle -> rsp_rdata=0xC3, rsp_valid 5 cycles after accept, PSEL2 never asserted.
- Timeout, TIMEOUT=3, PREADY held 0: exactly 4 ACCESS cycles -> rsp_valid=1, rsp_err=1, rsp_rdata=0, bus idles.
- Back-to-back: second command presented during the rsp_valid cycle -> accepted there; next SETUP follows immediately; PADDR unchanged between transfers when the address repeats.
- cmd_valid held during a transfer with changing cmd_wdata -> PWDATA stays at the originally accepted value; no extra transfer is issued.
